// File: rtl/joypad_pkg.sv
// Shared constants for the NES joypad emulator: button bit positions,
// synchronizer depth and synchronizer idle levels.
package joypad_pkg;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam int unsigned NUM_BUTTONS = 8;
    localparam int unsigned SYNC_STAGES = 2;

    localparam logic LATCH_IDLE = 1'b0;
    localparam logic JCLK_IDLE  = 1'b1;
    localparam logic BTN_IDLE   = 1'b1;

endpackage

// File: rtl/joypad_debounce.sv
// Shared-prescaler debouncer: a bit's state only follows its input once two
// consecutive tick samples agree. Inputs must already be synchronized.
module joypad_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 21477
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] state_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] agree_c;
    logic             tick_c;

    always_comb begin
        tick_c  = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
        agree_c = ~(samp_q ^ in_i);
        samp_d  = samp_q;
        state_d = state_q;
        if (tick_c) begin
            samp_d  = in_i;
            state_d = (state_q & ~agree_c) | (in_i & agree_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            samp_q  <= '0;
            state_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            samp_q  <= samp_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/joypad_emulator.sv
// NES controller (4021) emulation: debounced buttons shifted out active-low on
// console latch/clock strobes. Define JOYPAD_TURBO_EN to add turbo A/B.
module joypad_emulator #(
    parameter int unsigned DEBOUNCE_CYCLES = 21477,
    parameter int unsigned TURBO_DIV       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] buttons_n,
    input  logic [1:0] turbo_n,
    input  logic       joy_latch,
    input  logic       joy_clk,
    output logic       joy_data,
    output logic [7:0] buttons_state
);
    import joypad_pkg::*;

`ifdef JOYPAD_TURBO_EN
    localparam int unsigned DB_W = NUM_BUTTONS + 2;
`else
    localparam int unsigned DB_W = NUM_BUTTONS;
`endif

    logic [SYNC_STAGES-1:0]                  latch_sync_q, jclk_sync_q;
    logic [SYNC_STAGES-1:0][NUM_BUTTONS-1:0] btn_sync_q;
    logic                                    latch_prev_q, jclk_prev_q;
    logic [7:0]                              sr_q, sr_d;
    logic                                    joy_data_q;
    logic [DB_W-1:0]                         db_in_c, db_state_c;
    logic [7:0]                              st_c, rep_c;
    logic                                    latch_s_c, latch_rise_c, jclk_rise_c;
    logic                                    turbo_a_c, turbo_b_c;

    // Synchronizers and edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_sync_q <= {SYNC_STAGES{LATCH_IDLE}};
            jclk_sync_q  <= {SYNC_STAGES{JCLK_IDLE}};
            btn_sync_q   <= {(SYNC_STAGES * NUM_BUTTONS){BTN_IDLE}};
            latch_prev_q <= LATCH_IDLE;
            jclk_prev_q  <= JCLK_IDLE;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], joy_latch};
            jclk_sync_q  <= {jclk_sync_q[SYNC_STAGES-2:0], joy_clk};
            btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], buttons_n};
            latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
            jclk_prev_q  <= jclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign latch_s_c    = latch_sync_q[SYNC_STAGES-1];
    assign latch_rise_c = latch_s_c & ~latch_prev_q;
    assign jclk_rise_c  = jclk_sync_q[SYNC_STAGES-1] & ~jclk_prev_q;

`ifdef JOYPAD_TURBO_EN
    localparam int unsigned TC_W = $clog2(TURBO_DIV + 1);

    logic [SYNC_STAGES-1:0][1:0] turbo_sync_q;
    logic [TC_W-1:0]             tcnt_q, tcnt_d;
    logic                        phase_q, phase_d;

    // Phase flips on the first latch edge of every TURBO_DIV-edge group
    always_comb begin
        tcnt_d  = tcnt_q;
        phase_d = phase_q;
        if (latch_rise_c) begin
            tcnt_d  = (tcnt_q == TC_W'(TURBO_DIV - 1)) ? '0 : tcnt_q + TC_W'(1);
            phase_d = (tcnt_q == '0) ? ~phase_q : phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turbo_sync_q <= {(SYNC_STAGES * 2){BTN_IDLE}};
            tcnt_q       <= '0;
            phase_q      <= 1'b0;
        end else begin
            turbo_sync_q <= {turbo_sync_q[SYNC_STAGES-2:0], turbo_n};
            tcnt_q       <= tcnt_d;
            phase_q      <= phase_d;
        end
    end

    assign db_in_c   = {~turbo_sync_q[SYNC_STAGES-1], ~btn_sync_q[SYNC_STAGES-1]};
    assign turbo_a_c = db_state_c[NUM_BUTTONS]     & phase_q;
    assign turbo_b_c = db_state_c[NUM_BUTTONS + 1] & phase_q;
`else
    localparam int unsigned unused_turbo_div = TURBO_DIV;
    logic unused_turbo_c;

    assign unused_turbo_c = ^turbo_n;
    assign db_in_c        = ~btn_sync_q[SYNC_STAGES-1];
    assign turbo_a_c      = 1'b0;
    assign turbo_b_c      = 1'b0;
`endif

    joypad_debounce #(
        .WIDTH           (DB_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .in_i    (db_in_c),
        .state_o (db_state_c)
    );

    assign st_c = db_state_c[NUM_BUTTONS-1:0];

    always_comb begin
        rep_c             = '0;
        rep_c[BTN_A]      = st_c[BTN_A] | turbo_a_c;
        rep_c[BTN_B]      = st_c[BTN_B] | turbo_b_c;
        rep_c[BTN_SELECT] = st_c[BTN_SELECT];
        rep_c[BTN_START]  = st_c[BTN_START];
        rep_c[BTN_UP]     = st_c[BTN_UP];
        rep_c[BTN_DOWN]   = st_c[BTN_DOWN];
        rep_c[BTN_LEFT]   = st_c[BTN_LEFT];
        rep_c[BTN_RIGHT]  = st_c[BTN_RIGHT];
    end

    // Latch level loads transparently and so beats a coincident clock edge
    always_comb begin
        sr_d = sr_q;
        if (latch_s_c) begin
            sr_d = rep_c;
        end else if (jclk_rise_c) begin
            sr_d = {1'b1, sr_q[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q       <= '0;
            joy_data_q <= 1'b1;
        end else begin
            sr_q       <= sr_d;
            joy_data_q <= ~sr_q[0];
        end
    end

    assign joy_data      = joy_data_q;
    assign buttons_state = st_c;

endmodule

// File: tb/tb_joypad_emulator.sv
// Directed bench for joypad_emulator with a short debounce period.
module tb_joypad_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] buttons_n;
    logic [1:0] turbo_n;
    logic       joy_latch;
    logic       joy_clk;
    logic       joy_data;
    logic [7:0] buttons_state;

    int n_checks = 0;
    int n_fail   = 0;

    joypad_emulator #(
        .DEBOUNCE_CYCLES (8),
        .TURBO_DIV       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttons_n     (buttons_n),
        .turbo_n       (turbo_n),
        .joy_latch     (joy_latch),
        .joy_clk       (joy_clk),
        .joy_data      (joy_data),
        .buttons_state (buttons_state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pulse();
        joy_latch = 1'b1;
        cyc(6);
        joy_latch = 1'b0;
        cyc(6);
    endtask

    task automatic clk_pulse();
        joy_clk = 1'b0;
        cyc(6);
        joy_clk = 1'b1;
        cyc(6);
    endtask

    // Latch then 10 reads; bits[i] is joy_data just before the i-th rise
    task automatic read_frame(output logic [9:0] bits);
        latch_pulse();
        for (int i = 0; i < 10; i++) begin
            bits[i] = joy_data;
            clk_pulse();
        end
    endtask

    task automatic test_reset();
        buttons_n = 8'hFE;
        cyc(30);
        joy_latch = 1'b1;
        cyc(6);
        n_checks++;
        if (joy_data !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pre_data: got %b expected 0", joy_data);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (joy_data !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_data: got %b expected 1", joy_data);
        end
        n_checks++;
        if (buttons_state !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 00", buttons_state);
        end
        cyc(2);
        rst = 1'b0;
        joy_latch = 1'b0;
        cyc(6);
    endtask

    task automatic test_frame_read();
        logic [9:0] bits;
        buttons_n = 8'b1111_0110;
        cyc(30);
        n_checks++;
        if (buttons_state !== 8'h09) begin
            n_fail++;
            $display("FAIL frame_state: got %h expected 09", buttons_state);
        end
        read_frame(bits);
        for (int i = 0; i < 10; i++) begin
            logic [9:0] exp;
            exp = 10'b00_1111_0110;
            n_checks++;
            if (bits[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL frame_bit%0d: got %b expected %b", i, bits[i], exp[i]);
            end
        end
    endtask

    task automatic test_bounce();
        logic       seen;
        logic [9:0] bits;
        logic [9:0] exp;
        buttons_n = 8'hFF;
        cyc(30);
        buttons_n = 8'hFE;
        cyc(3);
        buttons_n = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            seen = seen | buttons_state[0];
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_state: got %b expected 0", seen);
        end
        read_frame(bits);
        exp = 10'b00_1111_1111;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bits[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL bounce_bit%0d: got %b expected %b", i, bits[i], exp[i]);
            end
        end
    endtask

    task automatic test_latch_held();
        buttons_n = 8'hFE;
        cyc(30);
        joy_latch = 1'b1;
        cyc(6);
        for (int i = 0; i < 4; i++) begin
            clk_pulse();
            n_checks++;
            if (joy_data !== 1'b0) begin
                n_fail++;
                $display("FAIL held_pulse%0d: got %b expected 0", i, joy_data);
            end
        end
        joy_latch = 1'b0;
        cyc(6);
        n_checks++;
        if (joy_data !== 1'b0) begin
            n_fail++;
            $display("FAIL held_first_a: got %b expected 0", joy_data);
        end
        clk_pulse();
        n_checks++;
        if (joy_data !== 1'b1) begin
            n_fail++;
            $display("FAIL held_then_b: got %b expected 1", joy_data);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [9:0] bits;
        logic [9:0] exp;
        latch_pulse();
        for (int i = 0; i < 3; i++) clk_pulse();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (joy_data !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_data: got %b expected 1", joy_data);
        end
        cyc(2);
        rst = 1'b0;
        cyc(30);
        read_frame(bits);
        exp = 10'b00_1111_1110;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bits[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL midreset_bit%0d: got %b expected %b", i, bits[i], exp[i]);
            end
        end
    endtask

`ifdef JOYPAD_TURBO_EN
    task automatic test_turbo();
        logic [7:0] exp;
        exp = 8'b1100_1100;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        buttons_n = 8'hFF;
        turbo_n   = 2'b10;
        cyc(30);
        for (int f = 0; f < 8; f++) begin
            latch_pulse();
            n_checks++;
            if (joy_data !== exp[f]) begin
                n_fail++;
                $display("FAIL turbo_frame%0d: got %b expected %b", f, joy_data, exp[f]);
            end
        end
        turbo_n = 2'b11;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        buttons_n = 8'hFF;
        turbo_n   = 2'b11;
        joy_latch = 1'b0;
        joy_clk   = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        test_reset();
        test_frame_read();
        test_bounce();
        test_latch_held();
        test_mid_frame_reset();
`ifdef JOYPAD_TURBO_EN
        test_turbo();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
